// File: rtl/iob_bus_arbiter2.sv
// iob_bus_arbiter2
//   Round-robin arbiter sharing one IOb native port between the CPU
//   instruction bus (s0) and data bus (s1). One transaction is in flight at
//   a time. The request is captured into the m_* registers and held until
//   the slave answers. The response is passed back combinationally to the
//   requester that owns the transaction.
//
//   Ports:
//     clk, resetn             clock, async active-low reset
//     s0_* / s1_*             requester ports (avalid/addr/wdata/wstrb in,
//                             rdata/rvalid out)
//     m_*                     shared slave port (avalid/addr/wdata/wstrb out,
//                             rdata/rvalid in)
//     err                     one-cycle pulse when the watchdog aborts
//
//   Optional feature, macro IOB_BUS_ARBITER2_TIMEOUT_EN:
//     A watchdog aborts a BUSY transaction after 2^TIMEOUT_W-1 cycles
//     without a response. The abort returns rdata=0 to the owner and
//     pulses err. When the macro is not defined, err is tied 0.
module iob_bus_arbiter2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                s0_avalid,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic                s0_rvalid,

  input  logic                s1_avalid,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic                s1_rvalid,

  output logic                m_avalid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,

  output logic                err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  logic [1:0] state;
  logic       last;   // index of the requester served most recently
  logic       busy0, busy1, busy;
  logic       gnt0, gnt1;
  logic       tmo;    // watchdog abort this cycle
  logic       done;   // transaction ends this cycle (response or abort)

  assign busy0 = (state == BUSY0);
  assign busy1 = (state == BUSY1);
  assign busy  = busy0 | busy1;

  // On a tie, the requester that was not served last wins.
  assign gnt0 = s0_avalid & (~s1_avalid |  last);
  assign gnt1 = s1_avalid & (~s0_avalid | ~last);

  assign done = busy & (m_rvalid | tmo);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      last    <= 1'b1;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            state   <= BUSY0;
            last    <= 1'b0;
            m_addr  <= s0_addr;
            m_wdata <= s0_wdata;
            m_wstrb <= s0_wstrb;
          end else if (gnt1) begin
            state   <= BUSY1;
            last    <= 1'b1;
            m_addr  <= s1_addr;
            m_wdata <= s1_wdata;
            m_wstrb <= s1_wstrb;
          end
        end
        BUSY0, BUSY1: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IOB_BUS_ARBITER2_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;

  // The counter is held at 0 in IDLE, so it starts at 0 on entry to BUSY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           wd_cnt <= '0;
    else if (!busy)        wd_cnt <= '0;
    else if (!m_rvalid)    wd_cnt <= wd_cnt + 1'b1;
  end

  // A real response in the limit cycle takes priority over the abort.
  assign tmo = busy & ~m_rvalid & (&wd_cnt);
  assign err = tmo;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // The request drops in the response cycle itself.
  assign m_avalid  = busy & ~done;

  assign s0_rvalid = busy0 & done;
  assign s1_rvalid = busy1 & done;
  // On an abort m_rvalid is low, so the returned data is 0.
  assign s0_rdata  = (busy0 & m_rvalid) ? m_rdata : '0;
  assign s1_rdata  = (busy1 & m_rvalid) ? m_rdata : '0;

endmodule

// File: tb/tb_iob_bus_arbiter2.sv
module tb_iob_bus_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s0_avalid = 0, s1_avalid = 0;
  logic [AW-1:0] s0_addr = 0, s1_addr = 0;
  logic [DW-1:0] s0_wdata = 0, s1_wdata = 0;
  logic [3:0]    s0_wstrb = 0, s1_wstrb = 0;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic          s0_rvalid, s1_rvalid;
  logic          m_avalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic [DW-1:0] m_rdata = 0;
  logic          m_rvalid = 0;
  logic          err;

  iob_bus_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .resetn(resetn),
    .s0_avalid(s0_avalid), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid),
    .s1_avalid(s1_avalid), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid),
    .m_avalid(m_avalid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: requested transactions per requester and the
  // round-robin history (who was served most recently).
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wdata[2];
  logic [3:0]    r_wstrb[2];
  int            served_last = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s);
    r_addr[n] = a; r_wdata[n] = d; r_wstrb[n] = s;
  endtask

  task automatic drive(input int n, input logic v);
    if (n == 0) begin
      s0_avalid = v; s0_addr = r_addr[0]; s0_wdata = r_wdata[0]; s0_wstrb = r_wstrb[0];
    end else begin
      s1_avalid = v; s1_addr = r_addr[1]; s1_wdata = r_wdata[1]; s1_wstrb = r_wstrb[1];
    end
  endtask

  // One arbitrated transaction: r0/r1 say who requests. The slave answers
  // lat cycles after the grant edge. If drop is set, the winner drops its
  // avalid early. The loser always withdraws after the grant.
  task automatic txn(input bit r0, input bit r1, input int lat, input bit drop,
                     input logic [DW-1:0] rd);
    int w;
    bit dropped;
    w = (r0 && r1) ? (served_last == 0 ? 1 : 0) : (r0 ? 0 : 1);
    dropped = 0;
    @(negedge clk);
    if (r0) drive(0, 1'b1);
    if (r1) drive(1, 1'b1);
    @(posedge clk); #1;
    served_last = w;
    chk("grant_avalid", m_avalid, 1);
    chk("grant_addr", m_addr, r_addr[w]);
    chk("grant_wdata", m_wdata, r_wdata[w]);
    chk("grant_wstrb", m_wstrb, r_wstrb[w]);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (w == 0) s1_avalid = 0; else s0_avalid = 0;
      if (drop && !dropped) begin
        if (w == 0) s0_avalid = 0; else s1_avalid = 0;
        dropped = 1;
      end
      #1;
      chk("wait_avalid", m_avalid, 1);
      chk("wait_rvalid", {s1_rvalid, s0_rvalid}, 0);
      chk("wait_err", err, 0);
    end
    @(negedge clk);
    if (w == 0) s1_avalid = 0; else s0_avalid = 0;
    if (drop && !dropped) begin
      if (w == 0) s0_avalid = 0; else s1_avalid = 0;
    end
    m_rvalid = 1; m_rdata = rd;
    #1;
    chk("rsp_rvalid", {s1_rvalid, s0_rvalid}, (w == 0) ? 2'b01 : 2'b10);
    chk("rsp_rdata", (w == 0) ? s0_rdata : s1_rdata, rd);
    chk("rsp_avalid", m_avalid, 0);
    chk("rsp_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    m_rvalid = 0;
    s0_avalid = 0; s1_avalid = 0;
    #1;
    chk("idle_avalid", m_avalid, 0);
    chk("idle_rvalid", {s1_rvalid, s0_rvalid}, 0);
  endtask

  initial begin
    bit a, b;
    int n;
    // reset state
    #2;
    chk("rst_avalid", m_avalid, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_wstrb", m_wstrb, 0);
    chk("rst_rvalid", {s1_rvalid, s0_rvalid}, 0);
    chk("rst_rdata", {s1_rdata, s0_rdata}, 0);
    chk("rst_err", err, 0);
    @(negedge clk); resetn = 1;

    // contention right after reset: s0 first, then alternation
    set_req(0, 32'h40, 32'h1, 4'h0);
    set_req(1, 32'h80, 32'h2, 4'h3);
    for (int i = 0; i < 4; i++) txn(1, 1, 1 + i, 0, $urandom);

    // single read
    set_req(0, 32'h100, 32'h0, 4'h0);
    txn(1, 0, 3, 0, 32'hDEADBEEF);

    // write
    set_req(1, 32'h2000, 32'h12345678, 4'hF);
    txn(0, 1, 2, 0, 32'h0);

    // abandoned request
    set_req(1, 32'h3000, 32'hA5A5A5A5, 4'h1);
    txn(0, 1, 3, 1, 32'h5555AAAA);

    // m_rvalid while IDLE is ignored
    @(negedge clk); m_rvalid = 1; m_rdata = 32'hFFFF0000; #1;
    chk("idle_rsp_rvalid", {s1_rvalid, s0_rvalid}, 0);
    chk("idle_rsp_avalid", m_avalid, 0);
    @(negedge clk); m_rvalid = 0; #1;
    chk("idle_rsp_after", m_avalid, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = 1'($urandom); b = 1'($urandom);
      if (!a && !b) a = 1;
      set_req(0, $urandom, $urandom, 4'($urandom_range(0, 15)));
      set_req(1, $urandom, $urandom, 4'($urandom_range(0, 15)));
      txn(a, b, $urandom_range(1, 5), 1'($urandom), $urandom);
    end

`ifdef IOB_BUS_ARBITER2_TIMEOUT_EN
    // watchdog abort: no response ever
    set_req(0, 32'h500, 32'h0, 4'h0);
    @(negedge clk); drive(0, 1'b1);
    @(posedge clk); #1;
    served_last = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (s0_rvalid) break;
      if (m_avalid) n++;
    end
    chk("wd_cycles", n, (1 << TW) - 1);
    chk("wd_rvalid", s0_rvalid, 1);
    chk("wd_rdata", s0_rdata, 0);
    chk("wd_err", err, 1);
    chk("wd_avalid", m_avalid, 0);
    @(posedge clk); @(negedge clk); s0_avalid = 0; #1;
    chk("wd_err_after", err, 0);
    chk("wd_idle", m_avalid, 0);
    // real response in exactly the limit cycle wins
    set_req(1, 32'h600, 32'h0, 4'h0);
    txn(0, 1, 1 << TW, 0, 32'hCAFEF00D);
`else
    n = 0;
`endif

    // reset in the middle of a BUSY1 transaction
    set_req(1, 32'h700, 32'h77, 4'h0);
    @(negedge clk); drive(1, 1'b1);
    @(posedge clk); #1;
    chk("mid_grant", m_avalid, 1);
    #2; m_rvalid = 1; m_rdata = 32'h1234; resetn = 0; #1;
    chk("mid_rst_avalid", m_avalid, 0);
    chk("mid_rst_rvalid", {s1_rvalid, s0_rvalid}, 0);
    chk("mid_rst_addr", m_addr, 0);
    s1_avalid = 0; m_rvalid = 0;
    @(negedge clk); resetn = 1;
    served_last = 1;
    set_req(0, 32'h800, 32'h8, 4'h0);
    set_req(1, 32'h900, 32'h9, 4'h0);
    txn(1, 1, 2, 0, 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
